// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Lets two requesters share the single memory_controller port:
//     - video line fetch (read, high priority)
//     - framebuffer fill (write)
//   Only one transaction is outstanding at a time. The address and write data are
//   registered. A starvation counter forces the writer in after WR_STARVE_LIMIT
//   consecutive video grants. A transaction that never completes is aborted after
//   TIMEOUT_CYCLES cycles in WAIT, and the sticky timeout flag is raised.
// Ports
//   clk50M, reset        : clock and synchronous active-high reset
//   vid_req/vid_addr     : video read request; the address is sampled in the grant cycle
//   vid_grant/vid_done   : 1-cycle pulses; vid_data is held until the next vid_done
//   wr_req/wr_addr/wr_data : write request; address and data are sampled in the grant cycle
//   wr_grant/wr_done     : 1-cycle pulses
//   mc_*                 : memory_controller handshake (mc_n_write_enable: 1 read, 0 write)
//   timeout              : sticky abort flag, cleared only by reset
module mem_bus_arbiter #(
    parameter int ADDR_W          = 24,
    parameter int DATA_W          = 16,
    parameter int WR_STARVE_LIMIT = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk50M,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_grant,
    output logic              vid_done,
    output logic [DATA_W-1:0] vid_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    output logic              wr_done,
    output logic              mc_request,
    output logic              mc_n_write_enable,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_data_write,
    input  logic [DATA_W-1:0] mc_data_read,
    input  logic              mc_data_ready,
    input  logic              mc_save_ready,
    input  logic              mc_busy,
    output logic              timeout
);
    localparam int SW = $clog2(WR_STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              owner_wr_q, owner_wr_d;
    logic              mc_request_q, mc_request_d;
    logic              nwe_q, nwe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_done_q, vid_done_d;
    logic              wr_done_q, wr_done_d;
    logic              timeout_q, timeout_d;
    logic              grant_vid, grant_wr, finish;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        tmo_cnt_d    = tmo_cnt_q;
        owner_wr_d   = owner_wr_q;
        mc_request_d = mc_request_q;
        nwe_d        = nwe_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        vid_data_d   = vid_data_q;
        vid_done_d   = 1'b0;
        wr_done_d    = 1'b0;
        timeout_d    = timeout_q;
        grant_vid    = 1'b0;
        grant_wr     = 1'b0;
        finish       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Once the writer stops asking, it owes nothing to the count.
                if (!wr_req) starve_d = '0;
                if (!mc_busy) begin
                    if (wr_req && (starve_q == STARVE_MAX || !vid_req)) grant_wr = 1'b1;
                    else if (vid_req)                                   grant_vid = 1'b1;
                end
                if (grant_wr) begin
                    starve_d   = '0;
                    owner_wr_d = 1'b1;
                    nwe_d      = 1'b0;
                    addr_d     = wr_addr;
                    wdata_d    = wr_data;
                end
                if (grant_vid) begin
                    if (wr_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                    owner_wr_d = 1'b0;
                    nwe_d      = 1'b1;
                    addr_d     = vid_addr;
                end
                if (grant_wr || grant_vid) begin
                    mc_request_d = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only the strobe that matches the owner's direction completes the transaction.
                if (!owner_wr_q && mc_data_ready) begin
                    vid_data_d = mc_data_read;
                    vid_done_d = 1'b1;
                    finish     = 1'b1;
                end else if (owner_wr_q && mc_save_ready) begin
                    wr_done_d = 1'b1;
                    finish    = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // On abort the owner still gets its done pulse, and vid_data keeps its old value.
                    timeout_d  = 1'b1;
                    vid_done_d = !owner_wr_q;
                    wr_done_d  = owner_wr_q;
                    finish     = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                if (finish) begin
                    mc_request_d = 1'b0;
                    state_d      = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!mc_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            tmo_cnt_q    <= '0;
            owner_wr_q   <= 1'b0;
            mc_request_q <= 1'b0;
            nwe_q        <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            vid_data_q   <= '0;
            vid_done_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            tmo_cnt_q    <= tmo_cnt_d;
            owner_wr_q   <= owner_wr_d;
            mc_request_q <= mc_request_d;
            nwe_q        <= nwe_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            vid_data_q   <= vid_data_d;
            vid_done_q   <= vid_done_d;
            wr_done_q    <= wr_done_d;
            timeout_q    <= timeout_d;
        end
    end

    // Grants are combinational pulses in the IDLE cycle. They are masked while reset is
    // asserted so that every output sits at its reset value.
    assign vid_grant         = grant_vid && !reset;
    assign wr_grant          = grant_wr && !reset;
    assign vid_done          = vid_done_q;
    assign vid_data          = vid_data_q;
    assign wr_done           = wr_done_q;
    assign mc_request        = mc_request_q;
    assign mc_n_write_enable = nwe_q;
    assign mc_addr           = addr_q;
    assign mc_data_write     = wdata_q;
    assign timeout           = timeout_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter. A behavioural memory controller answers each request
// after resp_delay cycles. Expected transactions are queued when they are requested and
// are checked when the done pulse appears.
module tb_mem_bus_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk50M = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0, wr_req = 1'b0, mc_busy = 1'b0;
    logic [AW-1:0] vid_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          vid_grant, vid_done, wr_grant, wr_done, mc_request, mc_n_write_enable, timeout;
    logic [DW-1:0] vid_data, mc_data_write;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data_read = '0;
    logic          mc_data_ready = 1'b0, mc_save_ready = 1'b0;

    logic          resp_en = 1'b1;
    int            resp_delay = 1;
    logic [DW-1:0] resp_data = '0;
    int            mc_cnt = 0;
    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;

    mem_bus_arbiter dut (
        .clk50M(clk50M), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant), .vid_done(vid_done),
        .vid_data(vid_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_grant(wr_grant), .wr_done(wr_done), .mc_request(mc_request),
        .mc_n_write_enable(mc_n_write_enable), .mc_addr(mc_addr), .mc_data_write(mc_data_write),
        .mc_data_read(mc_data_read), .mc_data_ready(mc_data_ready), .mc_save_ready(mc_save_ready),
        .mc_busy(mc_busy), .timeout(timeout)
    );

    always #10 clk50M = ~clk50M;

    // Memory controller model: the completion strobe matches the direction and is
    // asserted in WAIT cycle number resp_delay.
    always @(posedge clk50M) begin
        #1;
        mc_data_ready = 1'b0;
        mc_save_ready = 1'b0;
        if (mc_request && resp_en) begin
            mc_cnt = mc_cnt + 1;
            if (mc_cnt == resp_delay) begin
                if (mc_n_write_enable) begin
                    mc_data_read  = resp_data;
                    mc_data_ready = 1'b1;
                end else begin
                    mc_save_ready = 1'b1;
                end
            end
        end else if (!mc_request) begin
            mc_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk50M);
        #1;
    endtask

    task automatic sample();
        @(negedge clk50M);
    endtask

    task automatic test_reset();
        step(); step();
        sample();
        checks++;
        if ({vid_grant, vid_done, wr_grant, wr_done, mc_request, mc_n_write_enable, timeout} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000010",
                     {vid_grant, vid_done, wr_grant, wr_done, mc_request, mc_n_write_enable, timeout});
        end
        checks++;
        if ({vid_data, mc_addr, mc_data_write} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0", vid_data, mc_addr, mc_data_write);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_busy();
        step();
        mc_busy = 1'b1; vid_req = 1'b1; vid_addr = 24'h000020;
        resp_delay = 1; resp_data = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if ({vid_grant, wr_grant} !== 2'b00) begin
                errors++; $display("FAIL busy_nogrant got %b exp 00", {vid_grant, wr_grant});
            end
            step();
        end
        mc_busy = 1'b0;
        sample();
        checks++;
        if (vid_grant !== 1'b1) begin errors++; $display("FAIL busy_release got %b exp 1", vid_grant); end
        step();
        vid_req = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_video_read();
        int n;
        exp_t e;
        step();
        resp_en = 1'b1; resp_delay = 3; resp_data = 16'hA5C3;
        vid_req = 1'b1; vid_addr = 24'h000010;
        sb_q.push_back('{wr: 1'b0, addr: 24'h000010, data: 16'hA5C3});
        sample();
        checks++;
        if ({vid_grant, wr_grant} !== 2'b10) begin errors++; $display("FAIL rd_grant got %b exp 10", {vid_grant, wr_grant}); end
        step();
        vid_req = 1'b0; vid_addr = 24'hFFFFFF;
        sample();
        e = sb_q[0];
        checks++;
        if ({mc_request, mc_n_write_enable, vid_grant} !== 3'b110) begin
            errors++; $display("FAIL rd_wait got %b exp 110", {mc_request, mc_n_write_enable, vid_grant});
        end
        checks++;
        if (mc_addr !== e.addr) begin errors++; $display("FAIL rd_addr got %h exp %h", mc_addr, e.addr); end
        n = 0;
        while (!(vid_done || wr_done) && n < 50) begin sample(); n++; end
        checks++;
        if (n != 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", n); end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++;
        if ({vid_done, wr_done, mc_request} !== {~e.wr, e.wr, 1'b0}) begin
            errors++; $display("FAIL rd_done got %b exp 100", {vid_done, wr_done, mc_request});
        end
        checks++;
        if (vid_data !== e.data) begin errors++; $display("FAIL rd_data got %h exp %h", vid_data, e.data); end
        sample();
        checks++;
        if ({vid_done, mc_request} !== 2'b00 || vid_data !== e.data) begin
            errors++; $display("FAIL rd_after got %b %h exp 00 %h", {vid_done, mc_request}, vid_data, e.data);
        end
    endtask

    task automatic test_write();
        int n;
        logic vid_seen;
        exp_t e;
        step();
        resp_delay = 5;
        wr_req = 1'b1; wr_addr = 24'h012BFF; wr_data = 16'h7777;
        sb_q.push_back('{wr: 1'b1, addr: 24'h012BFF, data: 16'h7777});
        sample();
        checks++;
        if ({vid_grant, wr_grant} !== 2'b01) begin errors++; $display("FAIL wr_grant got %b exp 01", {vid_grant, wr_grant}); end
        step();
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        sample();
        e = sb_q[0];
        checks++;
        if ({mc_request, mc_n_write_enable} !== 2'b10 || mc_addr !== e.addr || mc_data_write !== e.data) begin
            errors++;
            $display("FAIL wr_wait got %b %h %h exp 10 %h %h", {mc_request, mc_n_write_enable},
                     mc_addr, mc_data_write, e.addr, e.data);
        end
        n = 0; vid_seen = 1'b0;
        while (!(vid_done || wr_done) && n < 50) begin
            sample(); n++;
            vid_seen = vid_seen | vid_grant | vid_done;
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL wr_latency got %0d exp 5", n); end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++;
        if ({vid_done, wr_done} !== {~e.wr, e.wr}) begin errors++; $display("FAIL wr_done got %b exp 01", {vid_done, wr_done}); end
        sample();
        vid_seen = vid_seen | vid_grant | vid_done;
        checks++;
        if (wr_done !== 1'b0 || vid_seen !== 1'b0) begin
            errors++; $display("FAIL wr_quiet got wr_done=%b vid=%b exp 0 0", wr_done, vid_seen);
        end
    endtask

    task automatic test_starve();
        bit gq[$];
        int starve, got, cyc;
        bit exp_w;
        starve = 0;
        for (int i = 0; i < 18; i++) begin
            if (starve == 8) begin gq.push_back(1'b1); starve = 0; end
            else begin gq.push_back(1'b0); starve++; end
        end
        step();
        resp_delay = 1; resp_data = 16'h2222;
        vid_req = 1'b1; wr_req = 1'b1; vid_addr = 24'h000100; wr_addr = 24'h000200; wr_data = 16'h3333;
        got = 0; cyc = 0;
        while (got < 18 && cyc < 300) begin
            sample(); cyc++;
            if (vid_grant || wr_grant) begin
                exp_w = gq.pop_front();
                checks++;
                if ({vid_grant, wr_grant} !== (exp_w ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL starve_seq[%0d] got %b exp %b", got, {vid_grant, wr_grant}, exp_w ? 2'b01 : 2'b10);
                end
                got++;
            end
        end
        checks++;
        if (got != 18) begin errors++; $display("FAIL starve_count got %0d exp 18", got); end
        step();
        vid_req = 1'b0; wr_req = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_simultaneous();
        int n;
        logic seen;
        exp_t e;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        resp_delay = 2; resp_data = 16'h1234;
        vid_req = 1'b1; vid_addr = 24'h000300;
        wr_req = 1'b1; wr_addr = 24'h000400; wr_data = 16'h4444;
        sb_q.push_back('{wr: 1'b0, addr: 24'h000300, data: 16'h1234});
        sb_q.push_back('{wr: 1'b1, addr: 24'h000400, data: 16'h4444});
        sample();
        checks++;
        if ({vid_grant, wr_grant} !== 2'b10) begin errors++; $display("FAIL sim_first got %b exp 10", {vid_grant, wr_grant}); end
        step();
        vid_req = 1'b0;
        n = 1; seen = 1'b0;
        sample();
        while (!wr_grant && n < 20) begin
            if (vid_done) begin
                seen = 1'b1;
                if (sb_q.size() > 0) e = sb_q.pop_front();
                checks++;
                if (e.wr !== 1'b0 || vid_data !== e.data) begin
                    errors++; $display("FAIL sim_vid_data got %h exp %h", vid_data, e.data);
                end
            end
            sample(); n++;
        end
        checks++;
        if (n != 4 || seen !== 1'b1) begin errors++; $display("FAIL sim_wr_after got cycle %0d done %b exp 4 1", n, seen); end
        step();
        wr_req = 1'b0;
        n = 0;
        while (!wr_done && n < 20) begin sample(); n++; end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++;
        if (wr_done !== 1'b1 || e.wr !== 1'b1 || mc_data_write !== e.data) begin
            errors++; $display("FAIL sim_wr_done got %b %h exp 1 %h", wr_done, mc_data_write, e.data);
        end
    endtask

    task automatic test_timeout();
        int n;
        exp_t e;
        step();
        resp_en = 1'b0;
        vid_req = 1'b1; vid_addr = 24'h000ABC;
        sample();
        checks++;
        if (vid_grant !== 1'b1) begin errors++; $display("FAIL tmo_grant got %b exp 1", vid_grant); end
        step();
        vid_req = 1'b0;
        sample();
        n = 0;
        while (mc_request && n < 2000) begin n++; sample(); end
        checks++;
        if (n != 1024) begin errors++; $display("FAIL tmo_len got %0d exp 1024", n); end
        checks++;
        if ({vid_done, wr_done, timeout} !== 3'b101 || vid_data !== 16'h1234) begin
            errors++; $display("FAIL tmo_abort got %b %h exp 101 1234", {vid_done, wr_done, timeout}, vid_data);
        end
        sample();
        checks++;
        if ({vid_done, timeout} !== 2'b01) begin errors++; $display("FAIL tmo_sticky got %b exp 01", {vid_done, timeout}); end
        step();
        resp_en = 1'b1; resp_delay = 2; resp_data = 16'h0F0F;
        vid_req = 1'b1; vid_addr = 24'h000ABD;
        sb_q.push_back('{wr: 1'b0, addr: 24'h000ABD, data: 16'h0F0F});
        step();
        vid_req = 1'b0;
        n = 0;
        while (!vid_done && n < 20) begin sample(); n++; end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++;
        if (vid_done !== 1'b1 || vid_data !== e.data || mc_addr !== e.addr || timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_next got %b %h %h %b exp 1 %h %h 1", vid_done, vid_data, mc_addr, timeout, e.data, e.addr);
        end
    endtask

    task automatic test_reset_mid();
        logic done_seen;
        int n;
        step();
        resp_en = 1'b0;
        wr_req = 1'b1; wr_addr = 24'h005555; wr_data = 16'hBEEF;
        sample();
        checks++;
        if (wr_grant !== 1'b1) begin errors++; $display("FAIL rst_grant got %b exp 1", wr_grant); end
        step();
        wr_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        sample();
        checks++;
        if ({mc_request, mc_n_write_enable, wr_done, timeout} !== 4'b0100 || mc_addr !== '0) begin
            errors++; $display("FAIL rst_mid got %b %h exp 0100 0", {mc_request, mc_n_write_enable, wr_done, timeout}, mc_addr);
        end
        step();
        reset = 1'b0; resp_en = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin sample(); done_seen = done_seen | wr_done | vid_done; end
        checks++;
        if (done_seen !== 1'b0) begin errors++; $display("FAIL rst_nodone got %b exp 0", done_seen); end
        step();
        resp_delay = 1; resp_data = 16'h5A5A;
        vid_req = 1'b1; vid_addr = 24'h000777;
        sample();
        checks++;
        if (vid_grant !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", vid_grant); end
        step();
        vid_req = 1'b0;
        n = 0;
        while (!vid_done && n < 20) begin sample(); n++; end
        checks++;
        if (vid_done !== 1'b1 || vid_data !== 16'h5A5A) begin
            errors++; $display("FAIL rst_after got %b %h exp 1 5a5a", vid_done, vid_data);
        end
    endtask

    initial begin
        test_reset();
        test_busy();
        test_video_read();
        test_write();
        test_starve();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no end exp finish");
        $fatal(1, "watchdog");
    end
endmodule
